// File: rtl/core_pkg.sv
// core_pkg: shared RV32I core widths and register-address type.
package core_pkg;
  localparam int REG_ADDR_W = 5;
  localparam int XLEN = 32;
  localparam int NUM_REGS = 32;
  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
endpackage

// File: rtl/operand_fetch_scoreboard.sv
// scoreboard: pending-write busy bits with set/clear/flush-clear and three lookups.
module scoreboard
  import core_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      set_en,
  input  reg_addr_t set_addr,
  input  logic      clr_en,
  input  reg_addr_t clr_addr,
  input  logic      fl_en,
  input  reg_addr_t fl_addr,
  input  reg_addr_t look_a,
  input  reg_addr_t look_b,
  input  reg_addr_t look_c,
  output logic      busy_a,
  output logic      busy_b,
  output logic      busy_c
);
  logic [NUM_REGS-1:0] r_busy, w_set, w_clr;
  always_comb begin
    w_set = set_en ? NUM_REGS'(1) << set_addr : '0;
    w_clr = (clr_en ? NUM_REGS'(1) << clr_addr : '0) | (fl_en ? NUM_REGS'(1) << fl_addr : '0);
  end
  // set after clear: a newly issued writer outranks the retiring one; x0 stays clear
  always_ff @(posedge clk)
    r_busy <= rst ? '0 : ((r_busy & ~w_clr) | w_set) & ~NUM_REGS'(1);
  assign busy_a = r_busy[look_a];
  assign busy_b = r_busy[look_b];
  assign busy_c = r_busy[look_c];
endmodule

// File: rtl/operand_fetch.sv
// operand_fetch: issue stage with writeback bypass, RAW/WAW scoreboard stall and a
// valid/ready output slot feeding Execute.
module operand_fetch
  import core_pkg::*;
#(
  parameter int UOP_W = 16,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  output logic             id_ready,
  input  reg_addr_t        id_rs1,
  input  reg_addr_t        id_rs2,
  input  reg_addr_t        id_rd,
  input  logic             id_rd_we,
  input  logic [UOP_W-1:0] id_uop,
  output reg_addr_t        rf_ra1,
  output reg_addr_t        rf_ra2,
  input  logic [XLEN-1:0]  rf_rd1,
  input  logic [XLEN-1:0]  rf_rd2,
  input  logic             wb_we,
  input  reg_addr_t        wb_wa,
  input  logic [XLEN-1:0]  wb_wd,
  input  logic             flush,
  output logic             ex_valid,
  input  logic             ex_ready,
  output logic [XLEN-1:0]  ex_op1,
  output logic [XLEN-1:0]  ex_op2,
  output reg_addr_t        ex_rd,
  output logic             ex_rd_we,
  output logic [UOP_W-1:0] ex_uop,
  output logic [CNT_W-1:0] stall_cnt
);
  typedef struct packed {
    logic [UOP_W-1:0] uop;
    reg_addr_t        rd;
    logic             rd_we;
  } issue_t;
  logic             r_valid;
  logic [XLEN-1:0]  r_op1, r_op2;
  issue_t           r_iss;
  logic [CNT_W-1:0] r_cnt;
  logic             w_hit1, w_hit2, w_hitd, w_b1, w_b2, w_bd, w_hazard, w_fire;
  logic [XLEN-1:0]  w_op1, w_op2;
  scoreboard u_sb (
    .clk      (clk),
    .rst      (rst),
    .set_en   (w_fire && id_rd_we && id_rd != '0),
    .set_addr (id_rd),
    .clr_en   (wb_we),
    .clr_addr (wb_wa),
    .fl_en    (flush && r_valid && r_iss.rd_we),
    .fl_addr  (r_iss.rd),
    .look_a   (id_rs1),
    .look_b   (id_rs2),
    .look_c   (id_rd),
    .busy_a   (w_b1),
    .busy_b   (w_b2),
    .busy_c   (w_bd)
  );
  // a register being written back this cycle is no longer a hazard
  always_comb begin
    w_hit1   = wb_we && wb_wa == id_rs1;
    w_hit2   = wb_we && wb_wa == id_rs2;
    w_hitd   = wb_we && wb_wa == id_rd;
    w_op1    = id_rs1 == '0 ? '0 : w_hit1 ? wb_wd : rf_rd1;
    w_op2    = id_rs2 == '0 ? '0 : w_hit2 ? wb_wd : rf_rd2;
    w_hazard = (id_rs1 != '0 && w_b1 && !w_hit1) ||
               (id_rs2 != '0 && w_b2 && !w_hit2) ||
               (id_rd_we && id_rd != '0 && w_bd && !w_hitd);
    id_ready = !flush && !w_hazard && (!r_valid || ex_ready);
    w_fire   = id_valid && id_ready;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_op1   <= '0;
      r_op2   <= '0;
      r_iss   <= '0;
    end else if (flush) begin
      r_valid <= 1'b0;
    end else if (w_fire) begin
      r_valid <= 1'b1;
      r_op1   <= w_op1;
      r_op2   <= w_op2;
      r_iss   <= '{uop: id_uop, rd: id_rd, rd_we: id_rd_we};
    end else if (ex_ready) begin
      r_valid <= 1'b0;
    end
  end
  always_ff @(posedge clk)
    if (rst) r_cnt <= '0;
    else if (id_valid && w_hazard && !flush && r_cnt != '1) r_cnt <= r_cnt + 1'b1;
  assign rf_ra1    = id_rs1;
  assign rf_ra2    = id_rs2;
  assign ex_valid  = r_valid;
  assign ex_op1    = r_op1;
  assign ex_op2    = r_op2;
  assign ex_rd     = r_iss.rd;
  assign ex_rd_we  = r_iss.rd_we;
  assign ex_uop    = r_iss.uop;
  assign stall_cnt = r_cnt;
endmodule

// File: doc/operand_fetch.md
Name: operand_fetch

Overview:
- Issue/operand-fetch stage of the RV32I integer core; sits directly upstream of the Execute stage and owns the register file's read ports.
- Accepts one decoded instruction per cycle and drives the register file read addresses.
- Bypasses same-cycle writeback data and tracks pending destination registers in a scoreboard. Stalls on RAW/WAW hazards.
- Registers the operands into a valid/ready pipeline slot that feeds the ALU.

Parameters:
UOP_W, 16, width of the opaque decoded-operation payload passed through to Execute
CNT_W, 32, width of the saturating hazard-stall counter

Ports:
clk  in  1  core clock; all state updates on rising edge
rst  in  1  synchronous reset, active-high
id_valid  in  1  decoded instruction present
id_ready  out  1  stage accepts instruction this cycle
id_rs1  in  5  source register 1
id_rs2  in  5  source register 2
id_rd  in  5  destination register
id_rd_we  in  1  instruction writes rd
id_uop  in  UOP_W  opaque operation payload
rf_ra1  out  5  register file read address 1
rf_ra2  out  5  register file read address 2
rf_rd1  in  32  register file read data 1 (combinational read, pre-write value)
rf_rd2  in  32  register file read data 2
wb_we  in  1  writeback enable (same signal driving the register file WE)
wb_wa  in  5  writeback address
wb_wd  in  32  writeback data
flush  in  1  kill the instruction held in the output slot (branch redirect)
ex_valid  out  1  output slot holds an instruction
ex_ready  in  1  Execute consumes the slot this cycle
ex_op1  out  32  operand 1
ex_op2  out  32  operand 2
ex_rd  out  5  destination register
ex_rd_we  out  1  destination write enable
ex_uop  out  UOP_W  payload
stall_cnt  out  CNT_W  cycles with id_valid=1 and a hazard present, saturating

Behaviour:
- Reset (rst=1 at clk edge): ex_valid=0, ex_op1=0, ex_op2=0, ex_rd=0, ex_rd_we=0, ex_uop=0, all busy bits=0, stall_cnt=0. Reset overrides flush, fire and writeback in the same cycle.
- rf_ra1=id_rs1 and rf_ra2=id_rs2, combinational, independent of id_valid.
- Operand select for each source s:
  - s==0 -> 0.
  - Else wb_we && wb_wa==s -> wb_wd (bypass; the register file still returns the old value in this cycle).
  - Else rf_rdN.
- Scoreboard busy[31:1]; x0 never busy.
- Hazard (combinational) is asserted when any of the following holds:
  - id_rs1!=0, busy[id_rs1], and not (wb_we && wb_wa==id_rs1).
  - Same condition for id_rs2.
  - id_rd_we, id_rd!=0, busy[id_rd], and not (wb_we && wb_wa==id_rd). This is the WAW stall; at most one outstanding write per register.
- id_ready = !flush && !hazard && (!ex_valid || ex_ready). id_ready may depend on id_rs*/id_rd (data-dependent ready, documented).
- fire = id_valid && id_ready.
- On fire:
  - Slot loads the selected operands and id_rd, id_rd_we, id_uop; ex_valid=1.
  - If id_rd_we && id_rd!=0, set busy[id_rd].
- Else if ex_valid && ex_ready: ex_valid=0; data fields hold their values.
- Writeback: wb_we && wb_wa!=0 clears busy[wb_wa].
  - Same register set by fire and cleared by writeback in the same cycle -> set wins (newer instruction).
- Flush:
  - ex_valid=0 next cycle.
  - If ex_valid && ex_rd_we && ex_rd!=0, clear busy[ex_rd]; the killed instruction never writes back.
  - No fire during flush.
  - If writeback targets a different register in the same cycle, both clears apply.
- stall_cnt increments when id_valid && hazard && !flush; holds at all-ones.
- Latency: one cycle from fire to ex_valid. Throughput: one instruction per cycle absent hazards.
- Execute must not assert wb_we for an instruction still in the slot; writeback always comes from later stages.

Decomposition:
- Shared package core_pkg holds: REG_ADDR_W=5, XLEN=32, NUM_REGS=32, and typedef reg_addr_t.
- The issue payload is carried as a packed struct issue_t {uop, rd, rd_we}.
- One sub-module: scoreboard. It holds the busy vector with set/clear/flush-clear ports and three combinational busy lookups.
- Operand muxing and the pipeline slot remain in operand_fetch.

Test Plan:
- Reset mid-stream: fire with rd=5, then assert rst -> ex_valid=0, busy[5]=0, stall_cnt=0 on the next cycle.
- RAW stall: issue add rd=3; next instruction rs1=3 -> id_ready=0 and stall_cnt increments each cycle. On wb_we=1, wb_wa=3, wb_wd=0x1234 -> fire that cycle with ex_op1=0x1234.
- Bypass without busy: wb_we=1, wb_wa=7, wb_wd=0xCAFEF00D, rf_rd2=0xDEADBEEF, id_rs2=7 -> ex_op2=0xCAFEF00D.
- x0 handling: rs1=0, rs2=0, rd=0 with rd_we=1, rf_rd1=0xFFFFFFFF -> ex_op1=0, ex_op2=0, no busy bit set, back-to-back fires with no stall.
- Flush: slot holds rd=9 with ex_ready=0; assert flush -> ex_valid=0, busy[9]=0, id_ready=0 during the flush cycle. A following rs1=9 issues without stall.
- Backpressure plus WAW:
  - ex_ready=0 holds the slot stable with id_ready=0.
  - With the slot drained, an instruction with rd=4 while busy[4] stalls until wb_wa=4.
  - A simultaneous fire of rd=4 with wb_wa=4 leaves busy[4]=1.
